// File: rtl/mem_test_sequencer_if.sv
// rtl/mem_test_sequencer_if.sv - command/read-data bus between the test sequencer and the memory controller
interface mem_test_sequencer_if #(
  parameter int CMD_WIDTH  = 25,
  parameter int DATA_WIDTH = 1024
);
  logic                  o_command_valid;
  logic [CMD_WIDTH-1:0]  o_command;
  logic [DATA_WIDTH-1:0] o_write_data;
  logic                  i_controller_ready;
  logic                  i_read_data_valid;
  logic [DATA_WIDTH-1:0] i_read_data;

  modport master (
    output o_command_valid,
    output o_command,
    output o_write_data,
    input  i_controller_ready,
    input  i_read_data_valid,
    input  i_read_data
  );

  modport slave (
    input  o_command_valid,
    input  o_command,
    input  o_write_data,
    output i_controller_ready,
    output i_read_data_valid,
    output i_read_data
  );
endinterface

// File: rtl/mem_test_sequencer.sv
// rtl/mem_test_sequencer.sv - write-then-read memory pattern test with in-order read checking
module mem_test_sequencer #(
  parameter int CMD_WIDTH  = 25,
  parameter int DATA_WIDTH = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 i_start,
  input  logic [21:0]          i_base_addr,
  input  logic [CNT_WIDTH-1:0] i_num_words,
  input  logic [31:0]          i_seed,
  mem_test_sequencer_if.master bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_error_count,
  output logic [CNT_WIDTH-1:0] o_first_err_idx
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [21:0]          base_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [31:0]          seed_q;
  logic [CNT_WIDTH-1:0] issue_q;
  logic [CNT_WIDTH-1:0] beat_q;
  logic [CNT_WIDTH-1:0] err_q;
  logic [CNT_WIDTH-1:0] first_q;

  logic                 cmd_valid;
  logic                 is_write;
  logic [21:0]          addr;
  logic                 xfer;
  logic                 last_issue;
  logic                 beat_accept;
  logic                 last_beat;
  logic                 beat_mismatch;

  // One 32-bit word (seed ^ index) replicated across the whole data bus.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] seed,
                                                    input logic [CNT_WIDTH-1:0] idx);
    logic [31:0] word;
    word = seed ^ 32'(idx);
    return {(DATA_WIDTH/32){word}};
  endfunction

  assign cmd_valid     = (state_q == WRITE) || (state_q == READ);
  assign is_write      = (state_q == WRITE);
  assign addr          = base_q + 22'(issue_q);
  assign xfer          = cmd_valid && bus.i_controller_ready;
  assign last_issue    = (issue_q == num_q - CNT_WIDTH'(1));
  assign beat_accept   = bus.i_read_data_valid && ((state_q == READ) || (state_q == DRAIN));
  assign last_beat     = (beat_q == num_q - CNT_WIDTH'(1));
  assign beat_mismatch = (bus.i_read_data != pattern(seed_q, beat_q));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A final read beat can arrive while still in READ only after the last read issued,
  // so beat completion takes priority over the READ->DRAIN move.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = (i_num_words == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (xfer && last_issue) begin
          state_d = READ;
        end
      end
      READ: begin
        if (beat_accept && last_beat) begin
          state_d = DONE;
        end else if (xfer && last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beat_accept && last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.o_command_valid = cmd_valid;
    bus.o_command       = '0;
    bus.o_write_data    = '0;
    if (cmd_valid) begin
      bus.o_command[CMD_WIDTH-1] = is_write;
      bus.o_command[21:0]        = addr;
      if (is_write) begin
        bus.o_write_data = pattern(seed_q, issue_q);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      base_q  <= '0;
      num_q   <= '0;
      seed_q  <= '0;
      issue_q <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      first_q <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            base_q  <= i_base_addr;
            num_q   <= i_num_words;
            seed_q  <= i_seed;
            issue_q <= '0;
            beat_q  <= '0;
            err_q   <= '0;
            first_q <= '1;
          end
        end
        WRITE: begin
          if (xfer) begin
            issue_q <= last_issue ? '0 : issue_q + CNT_WIDTH'(1);
          end
        end
        READ: begin
          if (xfer && !last_issue) begin
            issue_q <= issue_q + CNT_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase

      if (beat_accept) begin
        beat_q <= beat_q + CNT_WIDTH'(1);
        if (beat_mismatch) begin
          if (err_q != '1) begin
            err_q <= err_q + CNT_WIDTH'(1);
          end
          if (first_q == '1) begin
            first_q <= beat_q;
          end
        end
      end
    end
  end

  assign o_busy          = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
  assign o_done          = (state_q == DONE);
  assign o_error_count   = err_q;
  assign o_first_err_idx = first_q;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// tb/tb_mem_test_sequencer.sv - directed bench for mem_test_sequencer with an echoing memory agent
module tb_mem_test_sequencer;
  localparam int CW = 25;
  localparam int DW = 1024;
  localparam int NW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [21:0]   i_base_addr = '0;
  logic [NW-1:0] i_num_words = '0;
  logic [31:0]   i_seed = '0;
  logic          o_busy;
  logic          o_done;
  logic [NW-1:0] o_error_count;
  logic [NW-1:0] o_first_err_idx;

  always #5 ap_clk = ~ap_clk;

  mem_test_sequencer_if #(.CMD_WIDTH(CW), .DATA_WIDTH(DW)) bus ();

  mem_test_sequencer #(.CMD_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(NW)) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .i_start         (i_start),
    .i_base_addr     (i_base_addr),
    .i_num_words     (i_num_words),
    .i_seed          (i_seed),
    .bus             (bus),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_error_count   (o_error_count),
    .o_first_err_idx (o_first_err_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0] cmd_q[$];
  logic [DW-1:0] dat_q[$];
  logic [DW-1:0] mem[int];
  int            rd_total = 0;
  int            rd_mark = 0;
  int            inj_req = 0;
  int            inj_done = 0;
  int            ready_mode = 0;
  logic [7:0]    corrupt_mask = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory agent: logs transfers, stores writes, echoes reads a few cycles later, checks hold-stability.
  initial begin
    logic          held;
    logic [CW-1:0] hcmd;
    logic [DW-1:0] hdat;
    logic          pend;
    logic [DW-1:0] pdat;
    logic          pvv[3];
    logic [DW-1:0] pv[3];
    int            cyc;
    int            ord;
    int            a;
    held = 1'b0; hcmd = '0; hdat = '0; pend = 1'b0; pdat = '0; cyc = 0;
    for (int i = 0; i < 3; i++) begin pvv[i] = 1'b0; pv[i] = '0; end
    bus.i_controller_ready = 1'b1;
    bus.i_read_data_valid  = 1'b0;
    bus.i_read_data        = '0;
    forever begin
      @(negedge ap_clk);
      pend = 1'b0;
      if (held && bus.o_command_valid) begin
        chk("hold_cmd", 64'(bus.o_command), 64'(hcmd));
        chk("hold_data", 64'(bus.o_write_data == hdat), 64'd1);
      end
      held = bus.o_command_valid && !bus.i_controller_ready;
      hcmd = bus.o_command;
      hdat = bus.o_write_data;
      if (bus.o_command_valid && bus.i_controller_ready) begin
        cmd_q.push_back(bus.o_command);
        dat_q.push_back(bus.o_write_data);
        a = int'(bus.o_command[21:0]);
        if (bus.o_command[CW-1]) begin
          mem[a] = bus.o_write_data;
        end else begin
          ord  = rd_total - rd_mark;
          pdat = mem.exists(a) ? mem[a] : '0;
          if (ord < 8 && corrupt_mask[ord]) pdat[0] = ~pdat[0];
          pend = 1'b1;
          rd_total++;
        end
      end
      @(posedge ap_clk);
      #1;
      cyc++;
      if (inj_req != inj_done) begin
        bus.i_read_data_valid = 1'b1;
        bus.i_read_data       = {32{32'h0BADF00D}};
        inj_done++;
      end else begin
        bus.i_read_data_valid = pvv[0];
        bus.i_read_data       = pv[0];
      end
      pvv[0] = pvv[1]; pv[0] = pv[1];
      pvv[1] = pvv[2]; pv[1] = pv[2];
      pvv[2] = pend;   pv[2] = pdat;
      bus.i_controller_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end
  end

  task automatic start_test(input logic [21:0] base, input logic [NW-1:0] n, input logic [31:0] seed);
    @(posedge ap_clk);
    #1;
    rd_mark     = rd_total;
    i_base_addr = base;
    i_num_words = n;
    i_seed      = seed;
    i_start     = 1'b1;
    @(posedge ap_clk);
    #1;
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int got;
    got = 0;
    for (int c = 0; c < 400 && got == 0; c++) begin
      @(negedge ap_clk);
      if (o_done) got = 1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    @(negedge ap_clk);
    chk({tag, "_done_1cyc"}, 64'(o_done), 64'd0);
    chk({tag, "_busy_after"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    int b;
    int dones;
    int reached;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_valid", 64'(bus.o_command_valid), 64'd0);
    chk("rst_cmd", 64'(bus.o_command), 64'd0);
    chk("rst_wdata", 64'(bus.o_write_data == '0), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_error_count), 64'd0);
    chk("rst_first", 64'(o_first_err_idx), 64'hFFFF);
    ap_rst = 1'b0;

    // Nominal run
    b = cmd_q.size();
    start_test(22'h10, 16'd4, 32'hA5A5A5A5);
    chk("nom_busy", 64'(o_busy), 64'd1);
    wait_done("nom");
    chk("nom_xfers", 64'(cmd_q.size() - b), 64'd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nom_wr_cmd%0d", i), 64'(cmd_q[b+i]), 64'h1000010 + 64'(i));
      chk($sformatf("nom_rd_cmd%0d", i), 64'(cmd_q[b+4+i]), 64'h0000010 + 64'(i));
      chk($sformatf("nom_rd_data%0d", i), 64'(dat_q[b+4+i] == '0), 64'd1);
    end
    chk("nom_wdata0", 64'(dat_q[b] == {32{32'hA5A5A5A5}}), 64'd1);
    chk("nom_wdata3", 64'(dat_q[b+3] == {32{32'hA5A5A5A6}}), 64'd1);
    chk("nom_err", 64'(o_error_count), 64'd0);
    chk("nom_first", 64'(o_first_err_idx), 64'hFFFF);

    // Backpressure
    b = cmd_q.size();
    ready_mode = 1;
    start_test(22'h100, 16'd3, 32'h12345678);
    wait_done("bp");
    ready_mode = 0;
    chk("bp_xfers", 64'(cmd_q.size() - b), 64'd6);
    chk("bp_wr_cmd2", 64'(cmd_q[b+2]), 64'h1000102);
    chk("bp_rd_cmd0", 64'(cmd_q[b+3]), 64'h0000100);
    chk("bp_wdata1", 64'(dat_q[b+1] == {32{32'h12345679}}), 64'd1);
    chk("bp_err", 64'(o_error_count), 64'd0);

    // Error capture
    corrupt_mask = 8'b0000_1010;
    start_test(22'h20, 16'd4, 32'h0);
    wait_done("err");
    corrupt_mask = 8'b0;
    chk("err_count", 64'(o_error_count), 64'd2);
    chk("err_first", 64'(o_first_err_idx), 64'd1);
    repeat (5) @(negedge ap_clk);
    chk("err_hold_count", 64'(o_error_count), 64'd2);
    chk("err_hold_first", 64'(o_first_err_idx), 64'd1);

    // Zero words
    b = cmd_q.size();
    start_test(22'h5, 16'd0, 32'h1);
    @(negedge ap_clk);
    chk("zero_done", 64'(o_done), 64'd1);
    chk("zero_busy", 64'(o_busy), 64'd0);
    @(negedge ap_clk);
    chk("zero_done_1cyc", 64'(o_done), 64'd0);
    chk("zero_xfers", 64'(cmd_q.size() - b), 64'd0);
    chk("zero_err", 64'(o_error_count), 64'd0);
    chk("zero_first", 64'(o_first_err_idx), 64'hFFFF);

    // Address wrap
    b = cmd_q.size();
    start_test(22'h3FFFFE, 16'd3, 32'h0F0F0F0F);
    wait_done("wrap");
    chk("wrap_xfers", 64'(cmd_q.size() - b), 64'd6);
    chk("wrap_wr0", 64'(cmd_q[b]), 64'h13FFFFE);
    chk("wrap_wr1", 64'(cmd_q[b+1]), 64'h13FFFFF);
    chk("wrap_wr2", 64'(cmd_q[b+2]), 64'h1000000);
    chk("wrap_rd2", 64'(cmd_q[b+5]), 64'h0000000);
    chk("wrap_err", 64'(o_error_count), 64'd0);

    // Reset mid-READ
    start_test(22'h40, 16'd4, 32'h55AA55AA);
    reached = 0;
    for (int c = 0; c < 100 && reached == 0; c++) begin
      @(posedge ap_clk);
      if (rd_total - rd_mark >= 2) reached = 1;
    end
    chk("rstmid_reached", 64'(reached), 64'd1);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("rstmid_valid", 64'(bus.o_command_valid), 64'd0);
    chk("rstmid_busy", 64'(o_busy), 64'd0);
    chk("rstmid_done", 64'(o_done), 64'd0);
    chk("rstmid_first", 64'(o_first_err_idx), 64'hFFFF);
    ap_rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      if (o_done) dones++;
    end
    chk("rstmid_no_done", 64'(dones), 64'd0);
    chk("rstmid_err", 64'(o_error_count), 64'd0);

    b = cmd_q.size();
    start_test(22'h80, 16'd2, 32'h00000001);
    wait_done("clean");
    chk("clean_xfers", 64'(cmd_q.size() - b), 64'd4);
    chk("clean_rd1", 64'(cmd_q[b+3]), 64'h0000081);
    chk("clean_err", 64'(o_error_count), 64'd0);
    chk("clean_first", 64'(o_first_err_idx), 64'hFFFF);

    // Spurious beat in IDLE, start pulse and spurious beat during WRITE
    inj_req++;
    repeat (3) @(negedge ap_clk);
    chk("idle_beat_err", 64'(o_error_count), 64'd0);
    chk("idle_beat_busy", 64'(o_busy), 64'd0);
    b = cmd_q.size();
    ready_mode = 1;
    start_test(22'h40, 16'd4, 32'hDEADBEEF);
    @(posedge ap_clk);
    #1;
    i_base_addr = 22'h300;
    i_num_words = 16'd1;
    i_start     = 1'b1;
    inj_req++;
    @(posedge ap_clk);
    #1;
    i_start = 1'b0;
    chk("ign_busy", 64'(o_busy), 64'd1);
    wait_done("ign");
    ready_mode = 0;
    chk("ign_xfers", 64'(cmd_q.size() - b), 64'd8);
    chk("ign_wr0", 64'(cmd_q[b]), 64'h1000040);
    chk("ign_rd3", 64'(cmd_q[b+7]), 64'h0000043);
    chk("ign_err", 64'(o_error_count), 64'd0);
    chk("ign_first", 64'(o_first_err_idx), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
